// File: rtl/dbus_sram_responder_pkg.sv
// Shared data-bus types and the responder state encoding.
// Also holds the byte-merge helper used by the SRAM write port.
package dbus_sram_responder_pkg;

    typedef logic [63:0] word_t;
    typedef logic [7:0]  strobe_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic    valid;
        word_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } rsp_state_t;

    // Replace the bytes of old_word selected by strobe with those of new_word.
    function automatic word_t merge_bytes(input word_t old_word, input word_t new_word,
                                          input strobe_t strobe);
        word_t res;
        res = old_word;
        for (int i = 0; i < 8; i++) begin
            if (strobe[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dbus_sram_responder_sram.sv
// DEPTH x 64 array with a byte-enable write port and a synchronous read port.
// Read returns the pre-write word; kept as a separate module so a vendor macro can replace it.
module sram_bytewrite
    import dbus_sram_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  strobe_t       we,
    input  logic [AW-1:0] addr,
    input  word_t         wdata,
    output word_t         rdata
);

    word_t mem [DEPTH];

    // Synchronous read-before-write access on enable.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            if (we != 8'h00) begin
                mem[addr] <= merge_bytes(mem[addr], wdata, we);
            end
        end
    end

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus responder: accepts one request in IDLE, waits LATENCY cycles, then answers
// for exactly one cycle with the full pre-write word from the backing SRAM.
module dbus_sram_responder
    import dbus_sram_responder_pkg::*;
#(
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 2,
    parameter logic [63:0] BASE    = 64'h8000_0000
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       oob
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [63:0] SPAN     = 64'(DEPTH) * 64'd8;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    rsp_state_t state_r, state_nxt_s;
    logic [3:0] cnt_r, cnt_nxt_s;
    dbus_req_t  req_r, cur_s;
    logic       oob_r;
    word_t      hold_r, sram_q_s, data_s, offset_s;
    logic       accept_s, enter_resp_s, in_range_s;
    logic       unused_s;

    // Next-state logic for the accept / countdown / respond sequence.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        accept_s     = 1'b0;
        enter_resp_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (dreq.valid) begin
                    accept_s = 1'b1;
                    if (LATENCY == 32'sd1) begin
                        state_nxt_s  = RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_nxt_s = WAIT;
                        cnt_nxt_s   = CNT_INIT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                cnt_nxt_s = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    state_nxt_s  = RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // With LATENCY==1 the array is accessed on the accept edge, before req_r is loaded.
    assign cur_s      = (state_r == IDLE) ? dreq : req_r;
    assign offset_s   = cur_s.addr - BASE;
    assign in_range_s = (offset_s < SPAN);
    assign unused_s   = ^{cur_s.valid, cur_s.size};

    sram_bytewrite #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk   (clk),
        .en    (enter_resp_s & in_range_s),
        .we    (cur_s.strobe),
        .addr  (offset_s[AW+2:3]),
        .wdata (cur_s.data),
        .rdata (sram_q_s)
    );

    // State, countdown, latched request and held response data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            req_r   <= '0;
            oob_r   <= 1'b0;
            hold_r  <= 64'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (accept_s) begin
                req_r <= dreq;
            end
            if (enter_resp_s) begin
                oob_r <= ~in_range_s;
            end
            if (state_r == RESP) begin
                hold_r <= data_s;
            end
        end
    end

    assign data_s        = (state_r == RESP) ? (oob_r ? 64'd0 : sram_q_s) : hold_r;
    assign dresp.addr_ok = dreq.valid & (state_r == IDLE);
    assign dresp.data_ok = (state_r == RESP);
    assign dresp.data    = data_s;
    assign oob           = (state_r == RESP) & oob_r;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench: a table of single transactions on a LATENCY=2 responder plus
// hand-written sequences for back-to-back, mid-WAIT changes and reset during WAIT.
module tb_dbus_sram_responder;
    import dbus_sram_responder_pkg::*;

    localparam logic [63:0] B = 64'h8000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst2, rst3, oob2, oob3;
    dbus_req_t  req2, req3;
    dbus_resp_t resp2, resp3;

    dbus_sram_responder #(.DEPTH(1024), .LATENCY(2), .BASE(B)) d2 (
        .clk(clk), .reset(rst2), .dreq(req2), .dresp(resp2), .oob(oob2));
    dbus_sram_responder #(.DEPTH(16), .LATENCY(3), .BASE(B)) d3 (
        .clk(clk), .reset(rst3), .dreq(req3), .dresp(resp3), .oob(oob3));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    typedef struct {
        string       nm;
        logic [63:0] addr;
        logic [7:0]  strb;
        logic [63:0] wd;
        logic        chk_d;
        logic [63:0] exp_d;
        logic        exp_oob;
    } vec_t;

    vec_t v [18];

    task automatic drive2(input logic [63:0] addr, input logic [7:0] strb, input logic [63:0] wd);
        req2.valid  = 1'b1;
        req2.addr   = addr;
        req2.size   = MSIZE8;
        req2.strobe = strb;
        req2.data   = wd;
    endtask

    // One full transaction on d2, checking cycle-exact timing.
    task automatic txn2(input vec_t t);
        @(negedge clk);
        drive2(t.addr, t.strb, t.wd);
        #1;
        chk({t.nm, ".addr_ok_T"}, 64'(resp2.addr_ok), 64'd1);
        @(negedge clk);
        chk({t.nm, ".data_ok_T1"}, 64'(resp2.data_ok), 64'd0);
        chk({t.nm, ".addr_ok_T1"}, 64'(resp2.addr_ok), 64'd0);
        @(negedge clk);
        chk({t.nm, ".data_ok_T2"}, 64'(resp2.data_ok), 64'd1);
        chk({t.nm, ".oob_T2"}, 64'(oob2), 64'(t.exp_oob));
        if (t.chk_d) chk({t.nm, ".data"}, resp2.data, t.exp_d);
        req2.valid = 1'b0;
        @(negedge clk);
        chk({t.nm, ".data_ok_after"}, 64'(resp2.data_ok), 64'd0);
        chk({t.nm, ".oob_after"}, 64'(oob2), 64'd0);
        if (t.chk_d) chk({t.nm, ".data_hold"}, resp2.data, t.exp_d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time expired, required $finish before 100000");
        $fatal(1);
    end

    initial begin
        v[0]  = '{"pre10",   B + 64'h10,   8'hFF, 64'h1122334455667788, 1'b0, 64'h0, 1'b0};
        v[1]  = '{"rd10",    B + 64'h10,   8'h00, 64'h0, 1'b1, 64'h1122334455667788, 1'b0};
        v[2]  = '{"st10",    B + 64'h10,   8'h0F, 64'hAAAAAAAA_DEADBEEF, 1'b1, 64'h1122334455667788, 1'b0};
        v[3]  = '{"rd10b",   B + 64'h10,   8'h00, 64'h0, 1'b1, 64'h11223344_DEADBEEF, 1'b0};
        v[4]  = '{"rd13",    B + 64'h13,   8'h00, 64'h0, 1'b1, 64'h11223344_DEADBEEF, 1'b0};
        v[5]  = '{"pre0",    B,            8'hFF, 64'h5555555555555555, 1'b0, 64'h0, 1'b0};
        v[6]  = '{"pre20",   B + 64'h20,   8'hFF, 64'h0A0A0A0A0A0A0A0A, 1'b0, 64'h0, 1'b0};
        v[7]  = '{"pre28",   B + 64'h28,   8'hFF, 64'h0B0B0B0B0B0B0B0B, 1'b0, 64'h0, 1'b0};
        v[8]  = '{"prelast", B + 64'h1FF8, 8'hFF, 64'h0123456789ABCDEF, 1'b0, 64'h0, 1'b0};
        v[9]  = '{"rdlast",  B + 64'h1FF8, 8'h00, 64'h0, 1'b1, 64'h0123456789ABCDEF, 1'b0};
        v[10] = '{"rdlo",    B - 64'h8,    8'h00, 64'h0, 1'b1, 64'h0, 1'b1};
        v[11] = '{"rdhi",    B + 64'h2000, 8'h00, 64'h0, 1'b1, 64'h0, 1'b1};
        v[12] = '{"sthi",    B + 64'h2000, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h0, 1'b1};
        v[13] = '{"stlo",    B - 64'h8,    8'hFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h0, 1'b1};
        v[14] = '{"rd0",     B,            8'h00, 64'h0, 1'b1, 64'h5555555555555555, 1'b0};
        v[15] = '{"rdlast2", B + 64'h1FF8, 8'h00, 64'h0, 1'b1, 64'h0123456789ABCDEF, 1'b0};
        v[16] = '{"st28",    B + 64'h28,   8'hA0, 64'hCCDDEEFF_11223344, 1'b1, 64'h0B0B0B0B0B0B0B0B, 1'b0};
        v[17] = '{"rd28",    B + 64'h28,   8'h00, 64'h0, 1'b1, 64'hCC0BEE0B_0B0B0B0B, 1'b0};

        req2 = '0;
        req3 = '0;
        rst2 = 1'b1;
        rst3 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.data_ok", 64'(resp2.data_ok), 64'd0);
        chk("rst.data", resp2.data, 64'd0);
        chk("rst.oob", 64'(oob2), 64'd0);
        chk("rst.addr_ok", 64'(resp2.addr_ok), 64'd0);
        chk("rst3.data_ok", 64'(resp3.data_ok), 64'd0);
        rst2 = 1'b0;
        rst3 = 1'b0;

        for (int i = 0; i < 18; i++) txn2(v[i]);

        // Valid dropped and address changed mid-WAIT: original request still completes.
        @(negedge clk);
        drive2(B + 64'h20, 8'h00, 64'h0);
        #1 chk("midwait.addr_ok", 64'(resp2.addr_ok), 64'd1);
        @(negedge clk);
        req2.valid = 1'b0;
        req2.addr  = B + 64'h28;
        @(negedge clk);
        chk("midwait.data_ok", 64'(resp2.data_ok), 64'd1);
        chk("midwait.data", resp2.data, 64'h0A0A0A0A0A0A0A0A);
        @(negedge clk);

        // Reset during WAIT of a store: outputs clear at once, the store is lost.
        @(negedge clk);
        drive2(B + 64'h10, 8'hFF, 64'h9999999999999999);
        #1 chk("rstwait.addr_ok", 64'(resp2.addr_ok), 64'd1);
        @(negedge clk);
        rst2 = 1'b1;
        req2.valid = 1'b0;
        #1;
        chk("rstwait.data_ok", 64'(resp2.data_ok), 64'd0);
        chk("rstwait.data", resp2.data, 64'd0);
        chk("rstwait.oob", 64'(oob2), 64'd0);
        chk("rstwait.addr_ok0", 64'(resp2.addr_ok), 64'd0);
        repeat (2) @(negedge clk);
        rst2 = 1'b0;
        txn2('{"rstwait.rd", B + 64'h10, 8'h00, 64'h0, 1'b1, 64'h11223344_DEADBEEF, 1'b0});

        // Valid held high across three requests on the LATENCY=3 responder.
        @(negedge clk);
        req3.valid  = 1'b1;
        req3.addr   = B + 64'h8;
        req3.size   = MSIZE8;
        req3.strobe = 8'h00;
        req3.data   = 64'h0;
        for (int c = 0; c < 12; c++) begin
            #1;
            chk($sformatf("b2b.addr_ok[%0d]", c), 64'(resp3.addr_ok), 64'((c % 4) == 0));
            chk($sformatf("b2b.data_ok[%0d]", c), 64'(resp3.data_ok), 64'((c % 4) == 3));
            chk($sformatf("b2b.oob[%0d]", c), 64'(oob3), 64'd0);
            @(negedge clk);
        end
        req3.valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
